// File: rtl/imem_resp_pkg.sv
// imem_resp_pkg
// Shared types and helpers for the instruction-fetch responder.
//   resp_t    : one response pipeline slot {valid, err, data}
//   CNT_W     : statistics counter width
//   CNT_MAX   : counter saturation value
//   addr_err  : fetch address error check (misaligned or beyond the array)
package imem_resp_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Data field width carried by a response slot; the top slices it down to
  // its own DATA_W, so DATA_W must not exceed this.
  localparam int RESP_DW = 32;

  // Widest fetch address addr_err accepts; narrower addresses are zero-extended.
  localparam int ADDR_MAX_W = 64;

  typedef struct packed {
    logic               valid;
    logic               err;
    logic [RESP_DW-1:0] data;
  } resp_t;

  // Error if the byte address is not word aligned, or if the word index
  // needs more than idx_w bits (index >= 2**idx_w).
  function automatic logic addr_err(input logic [ADDR_MAX_W-1:0] addr,
                                    input int unsigned           idx_w);
    logic [ADDR_MAX_W-1:0] hi;
    hi = addr >> (idx_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// imem_resp_pipe
// LATENCY-stage response shift register. Shifts every cycle (no backpressure).
//   clk_i, rst_i : clock, synchronous active-high reset (clears every slot)
//   in_i         : slot entering stage 0 (valid=0 when nothing was granted)
//   out_o        : last stage, i.e. the response presented this cycle
//   occ_o        : valid slots that are not retiring this cycle
module imem_resp_pipe
  import imem_resp_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int OCC_W   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  resp_t            in_i,
  output resp_t            out_o,
  output logic [OCC_W-1:0] occ_o
);

  resp_t [LATENCY-1:0] stage_q;
  resp_t [LATENCY-1:0] stage_d;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = in_i;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_o = stage_q[LATENCY-1];

  // The last stage is on the bus now and leaves at the next edge, so its slot
  // is free for a grant made this cycle; count only the earlier stages.
  always_comb begin
    occ_o = '0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      occ_o = occ_o + OCC_W'(stage_q[i].valid);
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder
// Responder end of the instruction-fetch bus. Grants word-aligned fetches,
// returns array words in order after LATENCY cycles, flags misaligned or
// out-of-range fetches, and keeps saturating fetch/error counts.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   req_i, addr_i, gnt_o      : fetch request / byte address / combinational grant
//   rvalid_o, rdata_o, err_o  : registered response
//   stall_i                   : wait-state injection, blocks grants only
//   prog_we_i/addr_i/wdata_i  : host port writing the word array
//   fetch_cnt_o, err_cnt_o    : saturating statistics
module instr_mem_responder
  import imem_resp_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_i,
  input  logic [ADDR_W-1:0]              addr_i,
  output logic                           gnt_o,
  output logic                           rvalid_o,
  output logic [DATA_W-1:0]              rdata_o,
  output logic                           err_o,
  input  logic                           stall_i,
  input  logic                           prog_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr_i,
  input  logic [DATA_W-1:0]              prog_wdata_i,
  output logic [CNT_W-1:0]               fetch_cnt_o,
  output logic [CNT_W-1:0]               err_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Wide enough for LATENCY+1, the largest legal MAX_OUTSTANDING.
  localparam int OCC_W = $clog2(LATENCY + 1) + 1;
  localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(MAX_OUTSTANDING);

  // Program storage; contents survive reset.
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Host writes land at the edge, so a same-cycle fetch of the same index
  // reads the old word. Writes are accepted during reset.
  always_ff @(posedge clk_i) begin
    if (prog_we_i) begin
      mem_q[prog_addr_i] <= prog_wdata_i;
    end
  end

  // ---------------------------------------------------------------- grant
  logic [OCC_W-1:0] occ;

  assign gnt_o = req_i & ~stall_i & ~rst_i & (occ < MAX_OCC);

  // ---------------------------------------------------------------- stage 0
  logic              req_err;
  logic [DATA_W-1:0] rd_word;
  resp_t             pipe_in;
  resp_t             pipe_out;

  always_comb begin
    req_err = addr_err(ADDR_MAX_W'(addr_i), IDX_W);
    rd_word = mem_q[addr_i[IDX_W+1:2]];
    pipe_in = '0;
    if (gnt_o) begin
      pipe_in.valid = 1'b1;
      pipe_in.err   = req_err;
      pipe_in.data  = req_err ? '0 : RESP_DW'(rd_word);
    end
  end

  imem_resp_pipe #(
    .LATENCY (LATENCY),
    .OCC_W   (OCC_W)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .in_i  (pipe_in),
    .out_o (pipe_out),
    .occ_o (occ)
  );

  assign rvalid_o = pipe_out.valid;
  assign err_o    = pipe_out.err;
  assign rdata_o  = pipe_out.data[DATA_W-1:0];

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (gnt_o && (fetch_cnt_q != CNT_MAX)) begin
      fetch_cnt_d = fetch_cnt_q + 1'b1;
    end
    if (pipe_out.valid && pipe_out.err && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder
// Directed bench. Two responders share every input: dut_a (LATENCY=1) covers
// data return, errors, stall and host-write ordering; dut_b (LATENCY=3,
// MAX_OUTSTANDING=2) covers the throttled grant pattern and mid-flight reset.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_wdata;

  logic        gnt_a, rv_a, err_a;
  logic [31:0] rd_a;
  logic [15:0] fcnt_a, ecnt_a;
  logic        gnt_b, rv_b, err_b;
  logic [31:0] rd_b;
  logic [15:0] fcnt_b, ecnt_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.LATENCY(1), .MAX_OUTSTANDING(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .gnt_o(gnt_a),
    .rvalid_o(rv_a), .rdata_o(rd_a), .err_o(err_a), .stall_i(stall),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata),
    .fetch_cnt_o(fcnt_a), .err_cnt_o(ecnt_a)
  );

  instr_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .gnt_o(gnt_b),
    .rvalid_o(rv_b), .rdata_o(rd_b), .err_o(err_b), .stall_i(stall),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata),
    .fetch_cnt_o(fcnt_b), .err_cnt_o(ecnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [8:0] gexp;
  logic [8:0] rexp;

  initial begin
    rst = 1'b1; req = 1'b1; addr = 32'h0; stall = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;

    // Load words 0..7 while in reset
    for (int i = 0; i < 8; i++) begin
      prog_we = 1'b1; prog_addr = 10'(i); prog_wdata = 32'h1000_0000 + 32'(i);
      nxt();
    end
    prog_we = 1'b0;
    smp();
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_rv_a", 32'(rv_a), 32'd0);
    chk("rst_rd_a", rd_a, 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_fcnt_a", 32'(fcnt_a), 32'd0);
    chk("rst_ecnt_a", 32'(ecnt_a), 32'd0);
    chk("rst_rv_b", 32'(rv_b), 32'd0);
    nxt();

    // Back-to-back fetches 0x0, 0x4, 0x8
    rst = 1'b0; req = 1'b1; addr = 32'h0;
    smp(); chk("b2b_gnt0", 32'(gnt_a), 32'd1); nxt();
    addr = 32'h4;
    smp(); chk("b2b_gnt1", 32'(gnt_a), 32'd1);
    chk("b2b_rv0", 32'(rv_a), 32'd1); chk("b2b_rd0", rd_a, 32'h1000_0000); nxt();
    addr = 32'h8;
    smp(); chk("b2b_gnt2", 32'(gnt_a), 32'd1); chk("b2b_rd1", rd_a, 32'h1000_0001); nxt();
    req = 1'b0;
    smp(); chk("b2b_rv2", 32'(rv_a), 32'd1); chk("b2b_rd2", rd_a, 32'h1000_0002);
    chk("b2b_err2", 32'(err_a), 32'd0); chk("b2b_fcnt", 32'(fcnt_a), 32'd3); nxt();

    // Misaligned then out-of-range
    req = 1'b1; addr = 32'h2;
    smp(); chk("mis_gnt", 32'(gnt_a), 32'd1); chk("mis_rv_pre", 32'(rv_a), 32'd0); nxt();
    addr = 32'h1000;
    smp(); chk("oor_gnt", 32'(gnt_a), 32'd1); chk("mis_rv", 32'(rv_a), 32'd1);
    chk("mis_err", 32'(err_a), 32'd1); chk("mis_rd", rd_a, 32'd0); nxt();
    req = 1'b0;
    smp(); chk("oor_rv", 32'(rv_a), 32'd1); chk("oor_err", 32'(err_a), 32'd1);
    chk("oor_rd", rd_a, 32'd0); nxt();
    smp(); chk("err_rv_idle", 32'(rv_a), 32'd0); chk("err_ecnt", 32'(ecnt_a), 32'd2);
    chk("err_fcnt", 32'(fcnt_a), 32'd5); nxt();

    // Stall for 4 cycles with a pending request
    stall = 1'b1; req = 1'b1; addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      smp(); chk("stall_gnt", 32'(gnt_a), 32'd0); chk("stall_rv", 32'(rv_a), 32'd0); nxt();
    end
    stall = 1'b0;
    smp(); chk("unstall_gnt", 32'(gnt_a), 32'd1); nxt();
    req = 1'b0;
    smp(); chk("unstall_rv", 32'(rv_a), 32'd1); chk("unstall_rd", rd_a, 32'h1000_0004); nxt();
    smp(); chk("unstall_single", 32'(rv_a), 32'd0); nxt();

    // Host write to index 5 in the same cycle as a fetch of 0x14
    req = 1'b1; addr = 32'h14; prog_we = 1'b1; prog_addr = 10'd5; prog_wdata = 32'hDEAD_BEEF;
    smp(); chk("rbw_gnt0", 32'(gnt_a), 32'd1); nxt();
    prog_we = 1'b0;
    smp(); chk("rbw_gnt1", 32'(gnt_a), 32'd1); chk("rbw_old", rd_a, 32'h1000_0005); nxt();
    req = 1'b0;
    smp(); chk("rbw_rv_new", 32'(rv_a), 32'd1); chk("rbw_new", rd_a, 32'hDEAD_BEEF); nxt();
    repeat (5) nxt();

    // LATENCY=3, MAX_OUTSTANDING=2 with request held for 6 cycles
    gexp = 9'b000011011;   // bit k = expected gnt in cycle k
    rexp = 9'b011011000;   // bit k = expected rvalid in cycle k
    req = 1'b1; addr = 32'h0;
    for (int k = 0; k < 9; k++) begin
      if (k == 6) req = 1'b0;
      smp();
      chk("thr_gnt", 32'(gnt_b), 32'(gexp[k]));
      chk("thr_rv", 32'(rv_b), 32'(rexp[k]));
      if (rexp[k]) chk("thr_rd", rd_b, 32'h1000_0000);
      nxt();
    end
    repeat (3) nxt();

    // Reset with two responses in flight on dut_b
    req = 1'b1; addr = 32'h4;
    smp(); chk("rst_fl_gnt0", 32'(gnt_b), 32'd1); nxt();
    smp(); chk("rst_fl_gnt1", 32'(gnt_b), 32'd1); nxt();
    req = 1'b0; rst = 1'b1;
    smp(); nxt();
    smp(); chk("rst_fl_rv0", 32'(rv_b), 32'd0); chk("rst_fl_fcnt", 32'(fcnt_b), 32'd0); nxt();
    req = 1'b1;
    smp(); chk("rst_fl_rv1", 32'(rv_b), 32'd0); chk("rst_fl_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_fl_gnt_a", 32'(gnt_a), 32'd0); nxt();
    rst = 1'b0; req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp(); chk("post_rst_rv", 32'(rv_b), 32'd0); nxt();
    end
    smp();
    chk("post_rst_fcnt_b", 32'(fcnt_b), 32'd0);
    chk("post_rst_ecnt_b", 32'(ecnt_b), 32'd0);
    chk("post_rst_fcnt_a", 32'(fcnt_a), 32'd0);
    chk("post_rst_ecnt_a", 32'(ecnt_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
